// File: rtl/if_fetch_exc_ctrl_if.sv
// ---------------------------------------------------------------------------
// if_fetch_exc_ctrl_if
//   Bundles the fetch controller's redirect inputs and its PC / IF-ID outputs.
//
//   Redirect side (driven by ID / CP0, the "master"):
//     stall, br_taken, br_target, exc_req, eret, epc
//   Fetch side (driven by the controller, the "slave"):
//     pc, fetch_en, ifid_pc, ifid_exc, ifid_exc_code, ifid_valid,
//     bad_addr, fault_cnt
// ---------------------------------------------------------------------------
interface if_fetch_exc_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 8
);
    logic              stall;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              exc_req;
    logic              eret;
    logic [ADDR_W-1:0] epc;

    logic [ADDR_W-1:0] pc;
    logic              fetch_en;
    logic [ADDR_W-1:0] ifid_pc;
    logic              ifid_exc;
    logic [4:0]        ifid_exc_code;
    logic              ifid_valid;
    logic [ADDR_W-1:0] bad_addr;
    logic [CNT_W-1:0]  fault_cnt;

    modport master (
        output stall, br_taken, br_target, exc_req, eret, epc,
        input  pc, fetch_en, ifid_pc, ifid_exc, ifid_exc_code, ifid_valid,
               bad_addr, fault_cnt
    );

    modport slave (
        input  stall, br_taken, br_target, exc_req, eret, epc,
        output pc, fetch_en, ifid_pc, ifid_exc, ifid_exc_code, ifid_valid,
               bad_addr, fault_cnt
    );
endinterface

// File: rtl/if_fetch_exc_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_exc_ctrl
//   Fetch-stage PC controller. Owns the PC register and chooses the next PC
//   (sequential, branch, exception handler, ERET). Every fetch address is
//   checked against the legal text window and alignment; a faulting fetch is
//   handed to ID once as an exception slot and fetch then freezes until CP0
//   redirects with exc_req or eret.
//
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - slave modport of if_fetch_exc_ctrl_if (redirect inputs,
//              pc/fetch_en to IM, IF/ID register, fault diagnostics)
// ---------------------------------------------------------------------------
module if_fetch_exc_ctrl #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] TEXT_BASE  = 32'h0000_3000,
    parameter logic [ADDR_W-1:0] TEXT_END   = 32'h0000_6ffc,
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_3000,
    parameter logic [ADDR_W-1:0] HANDLER_PC = 32'h0000_4180,
    parameter int unsigned       ALIGN_BITS = 2,
    parameter logic [4:0]        EXC_ADEL   = 5'd4,
    parameter int unsigned       CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    if_fetch_exc_ctrl_if.slave   bus
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FAULT = 1'b1;

    // Low-bit mask for the alignment check; all zeros when ALIGN_BITS is 0,
    // which disables the check without a zero-width slice.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~({ADDR_W{1'b1}} << ALIGN_BITS);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]        state_q,     state_d;
    logic [ADDR_W-1:0] pc_q,        pc_d;
    logic [ADDR_W-1:0] ifid_pc_q,   ifid_pc_d;
    logic              ifid_exc_q,  ifid_exc_d;
    logic [4:0]        ifid_code_q, ifid_code_d;
    logic              ifid_vld_q,  ifid_vld_d;
    logic [ADDR_W-1:0] bad_addr_q,  bad_addr_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;

    logic fault;

    // Fetch fault: outside the inclusive text window or misaligned.
    always_comb begin
        fault = (pc_q < TEXT_BASE) | (pc_q > TEXT_END) | (|(pc_q & ALIGN_MASK));
    end

    // Next-state selection. CP0 redirects beat everything (including stall
    // and FAULT); a faulting RUN cycle holds the PC so that bad_addr and the
    // IF/ID slot both carry the faulting address, and is counted only when it
    // actually moves to FAULT (i.e. not while stalled).
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ifid_pc_d   = ifid_pc_q;
        ifid_exc_d  = ifid_exc_q;
        ifid_code_d = ifid_code_q;
        ifid_vld_d  = ifid_vld_q;
        bad_addr_d  = bad_addr_q;
        cnt_d       = cnt_q;

        if (bus.exc_req || bus.eret || (state_q == ST_FAULT)) begin
            if (bus.exc_req) begin
                pc_d    = HANDLER_PC;
                state_d = ST_RUN;
            end else if (bus.eret) begin
                pc_d    = bus.epc;
                state_d = ST_RUN;
            end
            // Bubble on redirect, and on every unstalled cycle in FAULT so
            // the faulting slot reaches ID only once.
            if (bus.exc_req || bus.eret || !bus.stall) begin
                ifid_pc_d   = '0;
                ifid_exc_d  = 1'b0;
                ifid_code_d = 5'd0;
                ifid_vld_d  = 1'b0;
            end
        end else if (!bus.stall) begin
            ifid_pc_d   = pc_q;
            ifid_exc_d  = fault;
            ifid_code_d = fault ? EXC_ADEL : 5'd0;
            ifid_vld_d  = 1'b1;
            if (fault) begin
                state_d    = ST_FAULT;
                bad_addr_d = pc_q;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (bus.br_taken) begin
                pc_d = bus.br_target;
            end else begin
                pc_d = pc_q + ADDR_W'(4);
            end
        end
    end

    // State, PC, IF/ID boundary and fault diagnostics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            ifid_pc_q   <= '0;
            ifid_exc_q  <= 1'b0;
            ifid_code_q <= 5'd0;
            ifid_vld_q  <= 1'b0;
            bad_addr_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ifid_pc_q   <= ifid_pc_d;
            ifid_exc_q  <= ifid_exc_d;
            ifid_code_q <= ifid_code_d;
            ifid_vld_q  <= ifid_vld_d;
            bad_addr_q  <= bad_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.fetch_en      = (state_q == ST_RUN);
    assign bus.ifid_pc       = ifid_pc_q;
    assign bus.ifid_exc      = ifid_exc_q;
    assign bus.ifid_exc_code = ifid_code_q;
    assign bus.ifid_valid    = ifid_vld_q;
    assign bus.bad_addr      = bad_addr_q;
    assign bus.fault_cnt     = cnt_q;

endmodule

// File: tb/tb_if_fetch_exc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_exc_ctrl
//   Directed bench for if_fetch_exc_ctrl. Two instances share the same
//   stimulus: busA/dutA with the default 8-bit fault counter and busB/dutB
//   with a 2-bit counter to exercise saturation.
// ---------------------------------------------------------------------------
module tb_if_fetch_exc_ctrl;

    logic        clk;
    logic        rstN;
    logic        stall;
    logic        brTaken;
    logic [31:0] brTarget;
    logic        excReq;
    logic        eret;
    logic [31:0] epc;

    int totalChecks;
    int badChecks;

    if_fetch_exc_ctrl_if #(.ADDR_W(32), .CNT_W(8)) busA ();
    if_fetch_exc_ctrl_if #(.ADDR_W(32), .CNT_W(2)) busB ();

    assign busA.stall     = stall;
    assign busA.br_taken  = brTaken;
    assign busA.br_target = brTarget;
    assign busA.exc_req   = excReq;
    assign busA.eret      = eret;
    assign busA.epc       = epc;

    assign busB.stall     = stall;
    assign busB.br_taken  = brTaken;
    assign busB.br_target = brTarget;
    assign busB.exc_req   = excReq;
    assign busB.eret      = eret;
    assign busB.epc       = epc;

    if_fetch_exc_ctrl #(.CNT_W(8)) dutA (
        .clk   (clk),
        .rst_n (rstN),
        .bus   (busA.slave)
    );

    if_fetch_exc_ctrl #(.CNT_W(2)) dutB (
        .clk   (clk),
        .rst_n (rstN),
        .bus   (busB.slave)
    );

    // 10 ns clock; outputs are sampled on the falling edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs, then advance to the next falling edge.
    task automatic applyStimulus(input logic st, input logic br,
                                 input logic [31:0] tgt, input logic ex,
                                 input logic er, input logic [31:0] ep);
        stall    = st;
        brTaken  = br;
        brTarget = tgt;
        excReq   = ex;
        eret     = er;
        epc      = ep;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        totalChecks = 0;
        badChecks   = 0;
        rstN     = 1'b0;
        stall    = 1'b0;
        brTaken  = 1'b0;
        brTarget = 32'h0;
        excReq   = 1'b0;
        eret     = 1'b0;
        epc      = 32'h0;

        repeat (2) @(negedge clk);
        checkOutput("rst pc",       busA.pc,            32'h3000);
        checkOutput("rst fetch_en", busA.fetch_en,      1);
        checkOutput("rst ifid_pc",  busA.ifid_pc,       0);
        checkOutput("rst valid",    busA.ifid_valid,    0);
        checkOutput("rst exc",      busA.ifid_exc,      0);
        checkOutput("rst code",     busA.ifid_exc_code, 0);
        checkOutput("rst bad_addr", busA.bad_addr,      0);
        checkOutput("rst cnt",      busA.fault_cnt,     0);

        rstN = 1'b1;
        idle();
        checkOutput("seq1 pc",      busA.pc,         32'h3004);
        checkOutput("seq1 ifid_pc", busA.ifid_pc,    32'h3000);
        checkOutput("seq1 valid",   busA.ifid_valid, 1);
        checkOutput("seq1 exc",     busA.ifid_exc,   0);
        idle();
        checkOutput("seq2 pc",      busA.pc,         32'h3008);
        checkOutput("seq2 ifid_pc", busA.ifid_pc,    32'h3004);

        // Branch below TEXT_BASE.
        applyStimulus(1'b0, 1'b1, 32'h2ffc, 1'b0, 1'b0, 32'h0);
        checkOutput("br pc",        busA.pc,       32'h2ffc);
        checkOutput("br ifid_pc",   busA.ifid_pc,  32'h3008);
        checkOutput("br exc",       busA.ifid_exc, 0);
        idle();
        checkOutput("lo exc",       busA.ifid_exc,      1);
        checkOutput("lo code",      busA.ifid_exc_code, 4);
        checkOutput("lo ifid_pc",   busA.ifid_pc,       32'h2ffc);
        checkOutput("lo valid",     busA.ifid_valid,    1);
        checkOutput("lo pc",        busA.pc,            32'h2ffc);
        checkOutput("lo fetch_en",  busA.fetch_en,      0);
        checkOutput("lo bad_addr",  busA.bad_addr,      32'h2ffc);
        checkOutput("lo cnt",       busA.fault_cnt,     1);
        checkOutput("lo cntB",      busB.fault_cnt,     1);
        idle();
        checkOutput("frz pc",       busA.pc,         32'h2ffc);
        checkOutput("frz valid",    busA.ifid_valid, 0);
        checkOutput("frz exc",      busA.ifid_exc,   0);
        checkOutput("frz ifid_pc",  busA.ifid_pc,    0);
        checkOutput("frz cnt",      busA.fault_cnt,  1);

        // Branch is ignored while frozen.
        applyStimulus(1'b0, 1'b1, 32'h3100, 1'b0, 1'b0, 32'h0);
        checkOutput("frz br pc",    busA.pc,         32'h2ffc);

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("exc pc",       busA.pc,         32'h4180);
        checkOutput("exc fetch_en", busA.fetch_en,   1);
        checkOutput("exc valid",    busA.ifid_valid, 0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3010);
        checkOutput("eret pc",      busA.pc,         32'h3010);
        checkOutput("eret valid",   busA.ifid_valid, 0);
        idle();
        checkOutput("res pc",       busA.pc,         32'h3014);
        checkOutput("res ifid_pc",  busA.ifid_pc,    32'h3010);
        checkOutput("res valid",    busA.ifid_valid, 1);

        // Misaligned target.
        applyStimulus(1'b0, 1'b1, 32'h3002, 1'b0, 1'b0, 32'h0);
        checkOutput("mis pc",       busA.pc,       32'h3002);
        checkOutput("mis exc0",     busA.ifid_exc, 0);
        idle();
        checkOutput("mis exc",      busA.ifid_exc,      1);
        checkOutput("mis code",     busA.ifid_exc_code, 4);
        checkOutput("mis ifid_pc",  busA.ifid_pc,       32'h3002);
        checkOutput("mis bad_addr", busA.bad_addr,      32'h3002);
        checkOutput("mis cnt",      busA.fault_cnt,     2);
        checkOutput("mis cntB",     busB.fault_cnt,     2);
        idle();
        checkOutput("mis exc2",     busA.ifid_exc,  0);
        checkOutput("mis cnt2",     busA.fault_cnt, 2);

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3000);
        idle();
        checkOutput("rec pc",       busA.pc, 32'h3004);

        // Target above TEXT_END.
        applyStimulus(1'b0, 1'b1, 32'h7000, 1'b0, 1'b0, 32'h0);
        checkOutput("hi pc",        busA.pc, 32'h7000);
        idle();
        checkOutput("hi exc",       busA.ifid_exc,      1);
        checkOutput("hi code",      busA.ifid_exc_code, 4);
        checkOutput("hi bad_addr",  busA.bad_addr,      32'h7000);
        checkOutput("hi cnt",       busA.fault_cnt,     3);
        checkOutput("hi cntB",      busB.fault_cnt,     3);
        idle();
        checkOutput("hi exc2",      busA.ifid_exc, 0);

        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3000);
        idle();
        checkOutput("rec2 pc",      busA.pc,      32'h3004);
        checkOutput("rec2 ifid_pc", busA.ifid_pc, 32'h3000);

        // Stall with a pending branch holds everything.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h5000, 1'b0, 1'b0, 32'h0);
            checkOutput("stl pc",      busA.pc,         32'h3004);
            checkOutput("stl ifid_pc", busA.ifid_pc,    32'h3000);
            checkOutput("stl valid",   busA.ifid_valid, 1);
        end
        applyStimulus(1'b1, 1'b1, 32'h5000, 1'b1, 1'b0, 32'h0);
        checkOutput("stlx pc",      busA.pc,         32'h4180);
        checkOutput("stlx valid",   busA.ifid_valid, 0);

        // A stalled faulting cycle is not counted.
        applyStimulus(1'b0, 1'b1, 32'h2000, 1'b0, 1'b0, 32'h0);
        checkOutput("f4 pc",        busA.pc, 32'h2000);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("f4 stl cnt",   busA.fault_cnt, 3);
        checkOutput("f4 stl fe",    busA.fetch_en,  1);
        idle();
        checkOutput("f4 cnt",       busA.fault_cnt, 4);
        checkOutput("f4 cntB",      busB.fault_cnt, 3);
        checkOutput("f4 exc",       busA.ifid_exc,  1);

        // exc_req beats eret.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3000);
        checkOutput("both pc",      busA.pc, 32'h4180);

        applyStimulus(1'b0, 1'b1, 32'h7004, 1'b0, 1'b0, 32'h0);
        idle();
        checkOutput("f5 cnt",       busA.fault_cnt, 5);
        checkOutput("f5 cntB",      busB.fault_cnt, 3);
        checkOutput("f5 fetch_en",  busA.fetch_en,  0);

        // Asynchronous reset while frozen, away from any rising edge.
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("arst pc",       busA.pc,         32'h3000);
        checkOutput("arst fetch_en", busA.fetch_en,   1);
        checkOutput("arst cnt",      busA.fault_cnt,  0);
        checkOutput("arst cntB",     busB.fault_cnt,  0);
        checkOutput("arst bad_addr", busA.bad_addr,   0);
        checkOutput("arst valid",    busA.ifid_valid, 0);
        checkOutput("arst exc",      busA.ifid_exc,   0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
